// File: rtl/alu_sequencer.sv
// ALU operation sequencer: issues one ALU operation per accepted request, applies BCD
// nibble correction for decimal ADC/SBC and returns the result with N/Z/C/V flags.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_c,
    input  logic       req_v,
    input  logic       req_d,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_addc,
    output logic       alu_daa,
    output logic       alu_sums,
    output logic       alu_ands,
    output logic       alu_ors,
    output logic       alu_eors,
    output logic       alu_srs,
    input  logic [7:0] alu_out,
    input  logic       alu_acr,
    input  logic       alu_hc,
    input  logic       alu_avr,
    output logic       resp_valid,
    output logic [7:0] resp_result,
    output logic       resp_n,
    output logic       resp_z,
    output logic       resp_c,
    output logic       resp_v,
    output logic       resp_err
);

    // state | meaning
    // IDLE  | waiting for a request; req_ready high
    // EXEC  | alu inputs driven; alu result captured at the end of the cycle
    // DCORR | BCD nibble correction of the captured result (decimal ADC/SBC)
    // DONE  | resp_valid pulse with result and flags
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_DCORR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADC = 4'h0;
    localparam logic [3:0] OP_SBC = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_ORA = 4'h3;
    localparam logic [3:0] OP_EOR = 4'h4;
    localparam logic [3:0] OP_ASL = 4'h5;
    localparam logic [3:0] OP_LSR = 4'h6;
    localparam logic [3:0] OP_ROL = 4'h7;
    localparam logic [3:0] OP_ROR = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;
    localparam logic [3:0] OP_INC = 4'hA;
    localparam logic [3:0] OP_DEC = 4'hB;

    state_t     state;
    state_t     next_state;
    logic       accept;
    logic       dec_op;

    logic [3:0] op_q;
    logic       c_q;
    logic       v_q;
    logic       d_q;
    logic [7:0] r_q;
    logic       hc_q;
    logic       cy_q;
    logic       ov_q;

    logic       legal;
    logic [7:0] drv_a;
    logic [7:0] drv_b;
    logic       drv_addc;
    logic       drv_daa;
    logic [4:0] drv_sel;

    logic [7:0] fin_res;
    logic       fin_cy;
    logic       fin_ov;
    logic       fin_c;
    logic       fin_v;
    logic [3:0] lo_nib;
    logic [3:0] hi_nib;
    logic       uses_cy;
    logic       uses_ov;

    assign dec_op = d_q && ((op_q == OP_ADC) || (op_q == OP_SBC));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = legal ? S_EXEC : S_DONE;
                end
            end
            S_EXEC:  next_state = dec_op ? S_DCORR : S_DONE;
            S_DCORR: next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Request decode into alu drive values; drv_sel = {sums, ands, ors, eors, srs}.
    always_comb begin
        legal    = 1'b1;
        drv_a    = req_a;
        drv_b    = req_b;
        drv_addc = 1'b0;
        drv_daa  = 1'b0;
        drv_sel  = 5'b00000;
        case (req_op)
            OP_ADC: begin
                drv_addc = req_c;
                drv_daa  = req_d;
                drv_sel  = 5'b10000;
            end
            OP_SBC: begin
                drv_b    = ~req_b;
                drv_addc = req_c;
                drv_sel  = 5'b10000;
            end
            OP_AND: drv_sel = 5'b01000;
            OP_ORA: drv_sel = 5'b00100;
            OP_EOR: drv_sel = 5'b00010;
            OP_ASL: begin
                drv_b   = req_a;
                drv_sel = 5'b10000;
            end
            OP_ROL: begin
                drv_b    = req_a;
                drv_addc = req_c;
                drv_sel  = 5'b10000;
            end
            OP_LSR: begin
                drv_b   = 8'h00;
                drv_sel = 5'b00001;
            end
            OP_ROR: begin
                drv_b    = 8'h00;
                drv_addc = req_c;
                drv_sel  = 5'b00001;
            end
            OP_CMP: begin
                drv_b    = ~req_b;
                drv_addc = 1'b1;
                drv_sel  = 5'b10000;
            end
            OP_INC: begin
                drv_b    = 8'h00;
                drv_addc = 1'b1;
                drv_sel  = 5'b10000;
            end
            OP_DEC: begin
                drv_b   = 8'hFF;
                drv_sel = 5'b10000;
            end
            default: begin
                legal = 1'b0;
                drv_a = 8'h00;
                drv_b = 8'h00;
            end
        endcase
    end

    // In EXEC the result comes straight from the alu; in DCORR from the captured copy,
    // corrected per nibble with no carry between nibbles.
    always_comb begin
        lo_nib  = r_q[3:0];
        hi_nib  = r_q[7:4];
        fin_res = r_q;
        fin_cy  = cy_q;
        fin_ov  = ov_q;
        if (state == S_EXEC) begin
            fin_res = alu_out;
            fin_cy  = alu_acr;
            fin_ov  = alu_avr;
        end else begin
            if (op_q == OP_ADC) begin
                if (hc_q) lo_nib = lo_nib + 4'd6;
                if (cy_q) hi_nib = hi_nib + 4'd6;
            end else begin
                if (!hc_q) lo_nib = lo_nib - 4'd6;
                if (!cy_q) hi_nib = hi_nib - 4'd6;
            end
            fin_res = {hi_nib, lo_nib};
        end
    end

    always_comb begin
        uses_cy = 1'b0;
        uses_ov = 1'b0;
        case (op_q)
            OP_ADC, OP_SBC: begin
                uses_cy = 1'b1;
                uses_ov = 1'b1;
            end
            OP_CMP, OP_ASL, OP_ROL, OP_LSR, OP_ROR: uses_cy = 1'b1;
            default: begin
                uses_cy = 1'b0;
                uses_ov = 1'b0;
            end
        endcase
        fin_c = uses_cy ? fin_cy : c_q;
        fin_v = uses_ov ? fin_ov : v_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= 4'h0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            d_q         <= 1'b0;
            r_q         <= 8'h00;
            hc_q        <= 1'b0;
            cy_q        <= 1'b0;
            ov_q        <= 1'b0;
            alu_a       <= 8'h00;
            alu_b       <= 8'h00;
            alu_addc    <= 1'b0;
            alu_daa     <= 1'b0;
            alu_sums    <= 1'b0;
            alu_ands    <= 1'b0;
            alu_ors     <= 1'b0;
            alu_eors    <= 1'b0;
            alu_srs     <= 1'b0;
            resp_valid  <= 1'b0;
            resp_result <= 8'h00;
            resp_n      <= 1'b0;
            resp_z      <= 1'b0;
            resp_c      <= 1'b0;
            resp_v      <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            if (accept) begin
                op_q     <= req_op;
                c_q      <= req_c;
                v_q      <= req_v;
                d_q      <= req_d;
                alu_a    <= drv_a;
                alu_b    <= drv_b;
                alu_addc <= drv_addc;
                alu_daa  <= drv_daa;
                {alu_sums, alu_ands, alu_ors, alu_eors, alu_srs} <= drv_sel;
                if (!legal) begin
                    resp_valid  <= 1'b1;
                    resp_err    <= 1'b1;
                    resp_result <= req_a;
                    resp_n      <= req_a[7];
                    resp_z      <= (req_a == 8'h00);
                    resp_c      <= req_c;
                    resp_v      <= req_v;
                end
            end
            if (state == S_EXEC) begin
                r_q      <= alu_out;
                hc_q     <= alu_hc;
                cy_q     <= alu_acr;
                ov_q     <= alu_avr;
                alu_a    <= 8'h00;
                alu_b    <= 8'h00;
                alu_addc <= 1'b0;
                alu_daa  <= 1'b0;
                {alu_sums, alu_ands, alu_ors, alu_eors, alu_srs} <= 5'b00000;
            end
            if (((state == S_EXEC) && !dec_op) || (state == S_DCORR)) begin
                resp_valid  <= 1'b1;
                resp_err    <= 1'b0;
                resp_result <= fin_res;
                resp_n      <= fin_res[7];
                resp_z      <= (fin_res == 8'h00);
                resp_c      <= fin_c;
                resp_v      <= fin_v;
            end
        end
    end

endmodule
